// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, a runtime baud divisor, optional even parity
// and a registered level interrupt. Registers: 0 DATA, 1 STATUS, 2 CTRL, 3 DIV.
module uart_mmio_fifo #(
    parameter int CLKS_PER_BIT = 115,
    parameter int FIFO_DEPTH   = 8,
    parameter bit PARITY_EN    = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iMEM,
    input  logic        iRW,
    input  logic [1:0]  iADDR,
    input  logic [31:0] iWDATA,
    output logic [31:0] oRDATA,
    output logic        oTX_Serial,
    input  logic        iRX_Serial,
    output logic        oIRQ
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [15:0] DIV_RST = 16'(CLKS_PER_BIT);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    function automatic logic [7:0] sat_cnt(input logic [PW-1:0] c);
        logic [31:0] w;
        w = 32'(c);
        return (w > 32'd255) ? 8'hFF : w[7:0];
    endfunction

    logic        wr_data, wr_stat, wr_ctrl, wr_div, rd_data;
    logic [4:0]  ctrl_q, ctrl_d;
    logic [15:0] div_q, div_d;
    logic [3:0]  flags_q, flags_d;
    logic [31:0] rdata_q, rdata_d, status;
    logic        irq_q, irq_d;
    logic        unused_wdata;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, tx_cnt;
    logic          tx_full, tx_empty, tx_push, tx_pop, tx_flush, tx_ovf_set;
    logic [7:0]    tx_head;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d, rx_cnt;
    logic          rx_full, rx_empty, rx_push, rx_push_req, rx_pop, rx_flush, rx_ovf_set;
    logic [7:0]    rx_head;

    state_t      tx_state_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [7:0]  tx_shift_q;
    logic [2:0]  tx_bit_q;
    logic        tx_par_q, tx_stop_q, tx_line_q, tx_last, tx_stop_done, tx_busy;

    state_t      rx_state_q;
    logic [15:0] rx_cnt_q, rx_div_q, rx_half;
    logic [7:0]  rx_shift_q;
    logic [2:0]  rx_bit_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_par_q;
    logic        rx_last, rx_stop_smp, rx_par_bad, frame_err_set, par_err_set;

    assign wr_data  = iMEM & ~iRW & (iADDR == 2'd0);
    assign wr_stat  = iMEM & ~iRW & (iADDR == 2'd1);
    assign wr_ctrl  = iMEM & ~iRW & (iADDR == 2'd2);
    assign wr_div   = iMEM & ~iRW & (iADDR == 2'd3);
    assign rd_data  = iMEM &  iRW & (iADDR == 2'd0);
    assign unused_wdata = ^iWDATA[31:16];

    assign tx_full    = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign tx_empty   = (tx_wp_q == tx_rp_q);
    assign tx_cnt     = tx_wp_q - tx_rp_q;
    assign tx_head    = tx_mem[tx_rp_q[AW-1:0]];
    assign tx_flush   = wr_ctrl & iWDATA[5];
    assign tx_push    = wr_data & (~tx_full | tx_pop);
    assign tx_ovf_set = wr_data & tx_full & ~tx_pop;

    assign rx_full    = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign rx_empty   = (rx_wp_q == rx_rp_q);
    assign rx_cnt     = rx_wp_q - rx_rp_q;
    assign rx_head    = rx_mem[rx_rp_q[AW-1:0]];
    assign rx_flush   = wr_ctrl & iWDATA[6];
    assign rx_pop     = rd_data & ~rx_empty;
    assign rx_push    = rx_push_req & (~rx_full | rx_pop);
    assign rx_ovf_set = rx_push_req & rx_full & ~rx_pop;

    // A new frame may start straight out of the last stop bit, so back-to-back bytes have no gap.
    assign tx_last      = (tx_cnt_q == tx_div_q - 16'd1);
    assign tx_stop_done = (tx_state_q == S_STOP) && tx_last && (tx_stop_q == 1'(STOP_BITS - 1));
    assign tx_busy      = (tx_state_q != S_IDLE);
    assign tx_pop       = ctrl_q[0] & ~tx_empty & ((tx_state_q == S_IDLE) | tx_stop_done);

    assign rx_last       = (rx_cnt_q == rx_div_q - 16'd1);
    assign rx_half       = (rx_div_q >> 1) - 16'd1;
    assign rx_stop_smp   = (rx_state_q == S_STOP) && rx_last;
    assign rx_par_bad    = PARITY_EN && (rx_par_q != ^rx_shift_q);
    assign frame_err_set = rx_stop_smp & ~rx_s2_q;
    assign par_err_set   = rx_stop_smp & rx_s2_q & rx_par_bad;
    assign rx_push_req   = rx_stop_smp & rx_s2_q & ~rx_par_bad;

    assign status = {sat_cnt(tx_cnt), sat_cnt(rx_cnt), 7'b0, flags_q,
                     tx_busy, rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        tx_wp_d = tx_wp_q + PW'(tx_push);
        tx_rp_d = tx_flush ? tx_wp_q : tx_rp_q + PW'(tx_pop);
        rx_wp_d = rx_flush ? rx_wp_q : rx_wp_q + PW'(rx_push);
        rx_rp_d = rx_flush ? rx_wp_q : rx_rp_q + PW'(rx_pop);
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        div_d   = div_q;
        flags_d = flags_q;
        rdata_d = rdata_q;
        if (wr_ctrl) ctrl_d = iWDATA[4:0];
        if (wr_div)  div_d  = (iWDATA[15:0] < 16'd4) ? 16'd4 : iWDATA[15:0];
        if (wr_stat) flags_d = flags_q & ~iWDATA[8:5];
        flags_d = flags_d | {tx_ovf_set, par_err_set, frame_err_set, rx_ovf_set};
        if (iMEM && iRW) begin
            case (iADDR)
                2'd0:    rdata_d = {24'b0, rx_empty ? 8'h00 : rx_head};
                2'd1:    rdata_d = status;
                2'd2:    rdata_d = {27'b0, ctrl_q};
                default: rdata_d = {16'b0, div_q};
            endcase
        end
        irq_d = (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty & ~tx_busy) | (ctrl_q[4] & |flags_q);
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            ctrl_q  <= '0;
            div_q   <= DIV_RST;
            flags_q <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            div_q   <= div_d;
            flags_q <= flags_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
            tx_wp_q <= tx_wp_d;
            tx_rp_q <= tx_rp_d;
            rx_wp_q <= rx_wp_d;
            rx_rp_q <= rx_rp_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= iWDATA[7:0];
        if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_shift_q;
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            tx_state_q <= S_IDLE;
            tx_line_q  <= 1'b1;
            tx_cnt_q   <= '0;
            tx_div_q   <= DIV_RST;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
        end else if (tx_pop) begin
            tx_state_q <= S_START;
            tx_line_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_div_q   <= div_q;
            tx_shift_q <= tx_head;
            tx_par_q   <= ^tx_head;
        end else if (tx_state_q != S_IDLE) begin
            if (!tx_last) begin
                tx_cnt_q <= tx_cnt_q + 16'd1;
            end else begin
                tx_cnt_q <= '0;
                case (tx_state_q)
                    S_START: begin
                        tx_state_q <= S_DATA;
                        tx_line_q  <= tx_shift_q[0];
                        tx_bit_q   <= '0;
                    end
                    S_DATA: begin
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= PARITY_EN ? S_PAR : S_STOP;
                            tx_line_q  <= PARITY_EN ? tx_par_q : 1'b1;
                            tx_stop_q  <= 1'b0;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_line_q  <= tx_shift_q[1];
                        end
                    end
                    S_PAR: begin
                        tx_state_q <= S_STOP;
                        tx_line_q  <= 1'b1;
                        tx_stop_q  <= 1'b0;
                    end
                    S_STOP: begin
                        if (tx_stop_q != 1'(STOP_BITS - 1)) tx_stop_q <= tx_stop_q + 1'b1;
                        else                                tx_state_q <= S_IDLE;
                    end
                    default: tx_state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Start bit is confirmed at mid-bit; later bits are sampled one divisor period apart.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= DIV_RST;
            rx_bit_q   <= '0;
        end else begin
            rx_s1_q   <= iRX_Serial;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            case (rx_state_q)
                S_IDLE: begin
                    if (ctrl_q[1] && rx_prev_q && !rx_s2_q) begin
                        rx_state_q <= S_START;
                        rx_cnt_q   <= 16'd1;
                        rx_div_q   <= div_q;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == rx_half) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_last) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= PARITY_EN ? S_PAR : S_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                S_PAR: begin
                    if (rx_last) begin
                        rx_cnt_q   <= '0;
                        rx_par_q   <= rx_s2_q;
                        rx_state_q <= S_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (rx_last) rx_state_q <= S_IDLE;
                    else         rx_cnt_q   <= rx_cnt_q + 16'd1;
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    assign oRDATA     = rdata_q;
    assign oTX_Serial = tx_line_q;
    assign oIRQ       = irq_q;
endmodule

// File: doc/uart_mmio_fifo.md
Name: uart_mmio_fifo

Overview:
- Memory-mapped UART peripheral that replaces the hard-wired single-byte UART in the SoC top level.
- It sits on the core's data-memory path: iMEM/iRW select a transaction and iADDR selects one of four registers.
- TX and RX each have a parametrised FIFO.
- The baud divisor is runtime-programmable, parity is optional, and a level interrupt is provided for the core.

Parameters:
- CLKS_PER_BIT, 115: reset value of the baud divisor register (clocks per bit, must be ≥ 4).
- FIFO_DEPTH, 8: entries per FIFO; power of two, 2..256.
- PARITY_EN, 0: 1 adds an even-parity bit on TX and checks it on RX.
- STOP_BITS, 1: 1 or 2 stop bits on TX; RX checks the first stop bit only.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  synchronous reset, active-low.
- iMEM  in  1  transaction strobe, one cycle per access.
- iRW  in  1  1 = read, 0 = write.
- iADDR  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 DIV.
- iWDATA  in  32  write data.
- oRDATA  out  32  read data, registered.
- oTX_Serial  out  1  serial output, idle high.
- iRX_Serial  in  1  asynchronous serial input.
- oIRQ  out  1  level interrupt.

Behaviour:
- Reset (iRST=0 at a clock edge):
  - FIFOs empty; FSMs go to IDLE.
  - oTX_Serial=1, oRDATA=0, oIRQ=0.
  - CTRL=0, DIV=CLKS_PER_BIT, sticky flags cleared.
  - Reset asserted mid-frame aborts the frame immediately; the line returns high in the same edge.
- Register access:
  - Read data appears on oRDATA the cycle after iMEM&iRW (1-cycle latency).
  - oRDATA holds its value until the next read.
  - Writes take effect at the strobe edge.
- DATA (addr 0):
  - Write pushes iWDATA[7:0] into the TX FIFO; if the FIFO is full, the write is dropped and TXOVF is set.
  - Read returns {24'b0, RX head} and pops the FIFO; if the FIFO is empty, it returns 0 and nothing changes.
- STATUS (addr 1), read-only except W1C bits:
  - [0] TXFULL, [1] TXEMPTY, [2] RXFULL, [3] RXEMPTY, [4] TXBUSY.
  - [5] RXOVF, [6] FRAMEERR, [7] PARERR, [8] TXOVF (sticky; writing 1 clears).
  - [23:16] RX count, [31:24] TX count (saturate at 255).
- CTRL (addr 2):
  - [0] TXEN, [1] RXEN.
  - [2] IE_RXNE: IRQ when RX is not empty.
  - [3] IE_TXE: IRQ when the TX FIFO is empty and TX is idle.
  - [4] IE_ERR: IRQ when any sticky flag is set.
  - [5] TXFLUSH, [6] RXFLUSH: self-clearing; empties the FIFO in one cycle.
- DIV (addr 3):
  - [15:0] divisor; written values below 4 are clamped to 4.
  - A change takes effect at the next frame start; the current frame keeps its latched divisor.
- oIRQ is registered: the OR of enabled conditions, 1-cycle delay.
- FIFOs:
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - Full = MSBs differ and the rest are equal; empty = pointers equal.
  - Push and pop in the same cycle:
    - Allowed when full (the count is unchanged; the popped entry is replaced).
    - When empty, the pop is ignored and the push succeeds.
- TX FSM: IDLE → START → DATA(8, LSB first) → [PARITY] → STOP(×STOP_BITS) → IDLE.
  - Leaves IDLE when TXEN=1 and the FIFO is not empty; the pop and divisor latch happen on that edge.
  - Each state lasts exactly DIV clocks.
  - Back-to-back frames have no idle gap.
  - Clearing TXEN mid-frame completes the current frame.
- RX path:
  - Two-flop synchroniser.
  - FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - A falling edge in IDLE with RXEN=1 starts the frame; the line is sampled at DIV/2.
  - If the line is high at the mid-start sample, the frame is a glitch and the FSM returns to IDLE.
  - Bits are sampled every DIV clocks after that.
  - At STOP:
    - A low stop bit sets FRAMEERR and discards the byte.
    - A parity mismatch sets PARERR and discards the byte.
    - Otherwise the byte is pushed; if the FIFO is full, the byte is dropped and RXOVF is set.
  - A CPU pop and an RX push in the same cycle are both honoured.

Test Plan:
- Reset → STATUS read = 0x0000_000A; oTX_Serial=1; DIV read = 115.
- DIV=4, TXEN=1, write DATA=0xA5 → oTX_Serial shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 clocks; TXBUSY clears after 40 clocks.
- DIV=4, write 9 bytes with FIFO_DEPTH=8 → 8 bytes transmitted in order; TXOVF set; writing 0x100 to STATUS clears it.
- Loopback oTX_Serial→iRX_Serial, RXEN=1, IE_RXNE=1, send 0x3C → oIRQ rises; DATA read = 0x3C; RXEMPTY=1 afterward.
- Drive a 1-clock low glitch on iRX_Serial → no byte received and no error flags; a frame with its stop bit forced low → FRAMEERR=1 and RX FIFO empty.
- PARITY_EN=1, send 0x07 with wrong parity → PARERR=1; deassert iRST mid-frame → oTX_Serial=1 next cycle and all FIFOs empty.
